// File: rtl/blink_arbiter.sv
// blink_arbiter: shares one LED blink generator between NUM_REQ requesters.
// Requesters are granted round-robin. Each grant runs a burst of blinks, then
// a done pulse, then a dark gap of GAP_PERIODS blink periods.
// Optional feature macro: BLINK_ARBITER_ABORT_EN. When it is defined, dropping
// the winner's req during a burst aborts the burst without issuing done.
module blink_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_COUNT   = 100000000,
  parameter int GAP_PERIODS = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   req_blinks,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic                   blink_out
);

  // state | meaning
  // IDLE  | waiting for a request; arbitration happens here
  // BLINK | granted burst running, LED toggles every half period
  // GAP   | dark separation after a burst (or an aborted burst)
  typedef enum logic [1:0] {IDLE, BLINK, GAP} state_t;

  localparam int CW = $clog2(MAX_COUNT);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(MAX_COUNT / 2);
  localparam logic [3:0]    GAP_LAST = 4'((GAP_PERIODS == 0) ? 0 : GAP_PERIODS - 1);
  localparam logic [PW-1:0] PTR_INIT = PW'(NUM_REQ - 1);

  state_t            state, state_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [CW-1:0]     cnt, cnt_n, cnt_inc;
  logic [3:0]        rem, rem_n;
  logic [3:0]        gap_cnt, gap_n;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic              blink_n;
  logic              found;
  logic [PW-1:0]     pick;
  logic [3:0]        pick_blinks;
  int                idx;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

  // Round-robin search starting just after the last winner.
  always_comb begin
    found       = 1'b0;
    pick        = ptr;
    pick_blinks = 4'd0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        pick        = PW'(idx);
        pick_blinks = req_blinks[4*idx +: 4];
      end
    end
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    rem_n   = rem;
    gap_n   = gap_cnt;
    grant_n = '0;
    done_n  = '0;
    cnt_inc = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    case (state)
      IDLE: begin
        if (found) begin
          ptr_n   = pick;
          rem_n   = pick_blinks;
          cnt_n   = '0;
          gap_n   = '0;
          grant_n = onehot(pick);
          // A zero-blink burst completes in its single grant cycle.
          if (pick_blinks == 4'd0) done_n = onehot(pick);
          state_n = BLINK;
        end
      end
      BLINK: begin
        if (rem == 4'd0) begin
          state_n = IDLE;
`ifdef BLINK_ARBITER_ABORT_EN
        end else if (!req[ptr]) begin
          cnt_n   = '0;
          gap_n   = '0;
          state_n = (GAP_PERIODS == 0) ? IDLE : GAP;
`endif
        end else begin
          cnt_n   = cnt_inc;
          grant_n = onehot(ptr);
          if (cnt == CNT_LAST) begin
            rem_n = rem - 4'd1;
            if (rem == 4'd1) begin
              grant_n = '0;
              done_n  = onehot(ptr);
              gap_n   = '0;
              state_n = (GAP_PERIODS == 0) ? IDLE : GAP;
            end
          end
        end
      end
      GAP: begin
        cnt_n = cnt_inc;
        if (cnt == CNT_LAST) begin
          if (gap_cnt == GAP_LAST) state_n = IDLE;
          else                     gap_n   = gap_cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    blink_n = (state_n == BLINK) && (rem_n != 4'd0) && (cnt_n < CNT_HALF);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= PTR_INIT;
      cnt       <= '0;
      rem       <= 4'd0;
      gap_cnt   <= 4'd0;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      blink_out <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      rem       <= rem_n;
      gap_cnt   <= gap_n;
      grant     <= grant_n;
      done      <= done_n;
      busy      <= (state_n != IDLE);
      blink_out <= blink_n;
    end
  end

endmodule

// File: tb/tb_blink_arbiter.sv
// tb_blink_arbiter: directed scenarios followed by random traffic, every cycle
// checked against a timeline model built from burst start/end arithmetic.
module tb_blink_arbiter;

  localparam int NR = 4;
  localparam int MC = 4;
  localparam int GP = 1;

  logic            clock;
  logic            reset_n;
  logic [NR-1:0]   req;
  logic [4*NR-1:0] req_blinks;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   done;
  logic            busy;
  logic            blink_out;

  blink_arbiter #(.NUM_REQ(NR), .MAX_COUNT(MC), .GAP_PERIODS(GP)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .req_blinks (req_blinks),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .blink_out  (blink_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic            rst_v;
  logic [NR-1:0]   req_v;
  logic [4*NR-1:0] blk_v;
  logic            rand_mode;
  logic [NR-1:0]   done_e_now;

  // Model: current burst is granted from cycle m_s, blinks until m_be-1,
  // done lands on m_dc, and the arbiter is idle again from cycle m_ia.
  int m_s   = -100;
  int m_be  = -100;
  int m_ia  = 0;
  int m_dc  = -100;
  int m_w   = 0;
  int m_n   = 0;
  int m_ptr = NR - 1;

  function automatic logic [NR-1:0] oh(input int i);
    return NR'(1) << i;
  endfunction

  task automatic check(input int c);
    logic [NR-1:0] g_e, d_e;
    logic b_e, l_e;
    g_e = (c >= m_s && c < m_be) ? oh(m_w) : '0;
    d_e = (c == m_dc) ? oh(m_w) : '0;
    b_e = (c >= m_s && c < m_ia);
    l_e = (m_n > 0) && (c >= m_s) && (c < m_be) && (((c - m_s) % MC) < MC / 2);
    done_e_now = d_e;
    checks++;
    assert (grant === g_e) else begin
      errors++; $error("FAIL grant cyc=%0d got=%b exp=%b", c, grant, g_e);
    end
    checks++;
    assert (done === d_e) else begin
      errors++; $error("FAIL done cyc=%0d got=%b exp=%b", c, done, d_e);
    end
    checks++;
    assert (busy === b_e) else begin
      errors++; $error("FAIL busy cyc=%0d got=%b exp=%b", c, busy, b_e);
    end
    checks++;
    assert (blink_out === l_e) else begin
      errors++; $error("FAIL blink_out cyc=%0d got=%b exp=%b", c, blink_out, l_e);
    end
  endtask

  // Advance the model with the inputs sampled at the end of cycle c.
  task automatic model_update(input int c);
    int i;
    if (!rst_v) begin
      m_s = -100; m_be = -100; m_dc = -100; m_ia = c + 1; m_ptr = NR - 1; m_n = 0;
    end else if (c >= m_ia && req_v != '0) begin
      for (int k = 1; k <= NR; k++) begin
        i = (m_ptr + k) % NR;
        if (req_v[i]) break;
      end
      m_ptr = i;
      m_w   = i;
      m_n   = int'(blk_v[4*i +: 4]);
      m_s   = c + 1;
      if (m_n == 0) begin
        m_be = m_s + 1; m_ia = m_s + 1; m_dc = m_s;
      end else begin
        m_be = m_s + m_n * MC; m_ia = m_be + GP * MC; m_dc = m_be;
      end
    end
`ifdef BLINK_ARBITER_ABORT_EN
    else if (m_n > 0 && c >= m_s && c < m_be && !req_v[m_w]) begin
      m_be = c + 1; m_ia = c + 1 + GP * MC; m_dc = -100;
    end
`endif
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    check(cyc);
    req_v = req_v & ~done_e_now;
    if (rand_mode) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_v[i] && $urandom_range(0, 9) == 0) req_v[i] = 1'b1;
        blk_v[4*i +: 4] = 4'($urandom_range(0, 5));
      end
      rst_v = ($urandom_range(0, 299) != 0);
    end
    reset_n    = rst_v;
    req        = req_v;
    req_blinks = blk_v;
    model_update(cyc);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rand_mode  = 1'b0;
    rst_v      = 1'b0;
    req_v      = 4'b1111;
    blk_v      = {4'd1, 4'd1, 4'd1, 4'd1};
    reset_n    = rst_v;
    req        = req_v;
    req_blinks = blk_v;
    model_update(0);
    // Reset held three cycles with every request up.
    run(2);
    rst_v = 1'b1;
    run(60);
    // Single two-blink burst on requester 0.
    req_v = 4'b0001; blk_v = {4'd1, 4'd1, 4'd1, 4'd2};
    run(16);
    // Round robin over requesters 0, 1, 3.
    req_v = 4'b1011; blk_v = {4'd1, 4'd1, 4'd1, 4'd1};
    run(30);
    // Zero-blink request.
    req_v = 4'b0100; blk_v = {4'd1, 4'd0, 4'd1, 4'd1};
    run(4);
    // Request dropped mid-burst (abort only when the feature is built in).
    req_v = 4'b0010; blk_v = {4'd1, 4'd1, 4'd3, 4'd1};
    run(6);
    req_v = 4'b0000;
    run(16);
    // Reset during a four-blink burst, then check the pointer restarted.
    req_v = 4'b0100; blk_v = {4'd1, 4'd4, 4'd1, 4'd1};
    run(5);
    rst_v = 1'b0; req_v = 4'b1001; blk_v = {4'd1, 4'd1, 4'd1, 4'd1};
    run(1);
    rst_v = 1'b1;
    run(30);
    // Random traffic with occasional resets.
    rand_mode = 1'b1;
    run(1500);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blink_arbiter.md
# blink_arbiter

- Shares the single board LED blink generator between up to NUM_REQ requesters.
- Each requester asks for a burst of N blinks; the arbiter grants requesters round-robin and drives the blink waveform for the granted burst.
- Each burst ends with a done pulse, followed by a dark gap so consecutive bursts are visually separable.
- Sits between status sources (boot, link, error, heartbeat) and the LED pin.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_COUNT, 100000000: clock cycles per blink period, ≥ 2, even.
- GAP_PERIODS, 2: dark periods inserted after each burst, 0..15.
- clock  input  1  single clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req  input  NUM_REQ  per-requester request level; held until done.
- req_blinks  input  4*NUM_REQ  blink count per requester; slice i is bits [4i+3:4i], sampled only at grant.
- grant  output  NUM_REQ  one-hot; high while that requester's burst is running.
- done  output  NUM_REQ  one-hot, single-cycle completion pulse.
- busy  output  1  high in any state other than IDLE.
- blink_out  output  1  LED drive.

## Operation
- States are IDLE, BLINK and GAP.
- Reset state:
  - State is IDLE; grant, done, busy and blink_out are all 0.
  - Round-robin pointer is NUM_REQ-1, so req[0] wins the first arbitration.
  - Period counter is 0 and the remaining-blink counter is 0.
- IDLE:
  - If any req bit is set, select the first set bit searching from pointer+1 upward with wrap-around.
  - Set the pointer to the winner, latch its req_blinks slice into the 4-bit remaining-blink counter, and set its grant bit.
  - Clear the period counter and enter BLINK.
- Zero count:
  - A winner with req_blinks = 0 gets grant and done high together for one cycle, with blink_out 0 and no GAP.
  - The next cycle is IDLE.
- BLINK:
  - The period counter (width $clog2(MAX_COUNT)) counts 0..MAX_COUNT-1 and wraps.
  - blink_out = 1 while counter < MAX_COUNT/2, else 0.
  - On counter = MAX_COUNT-1, decrement the remaining-blink counter.
  - If remaining was 1 at that point: clear grant, pulse done for the winner next cycle, and enter GAP. If GAP_PERIODS = 0, enter IDLE instead.
- GAP:
  - blink_out = 0 for exactly GAP_PERIODS*MAX_COUNT cycles. The period counter is reused, plus a 4-bit gap-period counter.
  - Then enter IDLE.
  - Requests arriving during BLINK or GAP wait; there is no preemption.
- req_blinks changes after grant are ignored.
- A req still high in IDLE after its own done is arbitrated again like any other request.
- Reset asserted mid-operation:
  - All state returns to reset values on the next edge.
  - No done is issued for the interrupted burst.

## Timing
- Arbitration latency:
  - req sampled in IDLE at edge t gives grant and blink_out = 1 from cycle t+1.
  - The period counter is 0 at cycle t+1.
- A burst of N blinks occupies BLINK for exactly N*MAX_COUNT cycles, i.e. cycles t+1 .. t+N*MAX_COUNT.
- done pulses at cycle t+N*MAX_COUNT+1; grant is already 0 in that cycle.
- GAP occupies cycles t+N*MAX_COUNT+1 .. t+(N+GAP_PERIODS)*MAX_COUNT.
- The earliest next grant is one cycle after the first IDLE cycle.
- All outputs are registered; there is no combinational path from req to any output.

## Configuration
- BLINK_ARBITER_ABORT_EN defined:
  - Deasserting req[winner] during BLINK aborts the burst.
  - The next cycle has grant = 0, blink_out = 0 and no done pulse.
  - GAP runs normally (or IDLE if GAP_PERIODS = 0). The pointer stays on the aborted requester.
- BLINK_ARBITER_ABORT_EN undefined:
  - req is not examined after grant; the burst always runs to completion and issues done.

## Test plan
All scenarios use MAX_COUNT = 4 and GAP_PERIODS = 1 unless noted.
- Reset: hold reset_n = 0 for 3 cycles with req = 4'b1111 → grant = 0, done = 0, busy = 0, blink_out = 0 throughout; first grant is grant[0] one cycle after release.
- Single burst: req[0] = 1 with count 2, seen at cycle 0:
  - grant[0] is high for cycles 1..8.
  - blink_out is 1 on cycles 1,2,5,6 and 0 on cycles 3,4,7,8.
  - done[0] pulses at cycle 9, GAP covers 9..12 with blink_out 0, and IDLE is reached at 13.
- Round robin: req = 4'b1011 held with all counts 1, each requester dropping req on its done → grant order 0, 1, 3, then none; each burst spans 4 cycles followed by a 4-cycle gap.
- Zero count: req[2] with count 0 → grant[2] and done[2] both high in cycle 1 only, blink_out stays 0, IDLE in cycle 2.
- Abort (macro defined): req[1] count 3, drop req[1] at cycle 6 → grant[1] = 0 and blink_out = 0 from cycle 7, no done[1], GAP cycles 7..10.
  - With the macro undefined, the same stimulus gives done[1] at cycle 13.
- Reset mid-burst: assert reset_n = 0 at cycle 5 of a count-4 burst → all outputs 0 from cycle 6, no done, pointer reset so req[0] wins next.
